// File: rtl/dram_rd_arb_pkg.sv
// Shared types and constants for the two-requester DRAM read arbiter.
`timescale 1ns/1ps
package dram_rd_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_RUN       = 3'd3,
        ST_DONE      = 3'd4
    } arb_state_t;

    localparam logic REQ_PIP  = 1'b0;
    localparam logic REQ_BACK = 1'b1;

    localparam int unsigned DEFAULT_TIMEOUT = 32'd1024;

endpackage

// File: rtl/dram_read_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not granted last.
`timescale 1ns/1ps
module rr_pick2
    import dram_rd_arb_pkg::*;
(
    input  logic [1:0] pend,
    input  logic       last_grant,
    output logic       valid,
    output logic       grant
);

    // Grant selection from the pending mask
    always_comb begin
        valid = 1'b0;
        grant = REQ_PIP;
        case (pend)
            2'b01: begin
                valid = 1'b1;
                grant = REQ_PIP;
            end
            2'b10: begin
                valid = 1'b1;
                grant = REQ_BACK;
            end
            2'b11: begin
                valid = 1'b1;
                grant = ~last_grant;
            end
            default: begin
                valid = 1'b0;
                grant = REQ_PIP;
            end
        endcase
    end

endmodule

// File: rtl/dram_read_arbiter.sv
// Shares one DRAM burst-read port between the PIP (0) and background (1) picture readers.
// Define DRAM_ARB_WATCHDOG_EN to re-kick a request whose DRAM busy never rises within TIMEOUT cycles.
`timescale 1ns/1ps
module dram_read_arbiter
    import dram_rd_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req0_kick,
    input  logic [31:0] req0_read_num,
    input  logic [31:0] req0_read_addr,
    output logic        req0_busy,
    output logic [31:0] req0_buf_dout,
    output logic        req0_buf_we,
    input  logic        req1_kick,
    input  logic [31:0] req1_read_num,
    input  logic [31:0] req1_read_addr,
    output logic        req1_busy,
    output logic [31:0] req1_buf_dout,
    output logic        req1_buf_we,
    output logic        dram_kick,
    output logic [31:0] dram_read_num,
    output logic [31:0] dram_read_addr,
    input  logic        dram_busy,
    input  logic [31:0] dram_buf_dout,
    input  logic        dram_buf_we,
    output logic        arb_err
);

    arb_state_t  state_r;
    logic [1:0]  pend_r;
    logic        grant_r;
    logic        last_grant_r;
    logic [31:0] num0_r;
    logic [31:0] addr0_r;
    logic [31:0] num1_r;
    logic [31:0] addr1_r;
    logic        pick_valid_s;
    logic        pick_grant_s;
    logic        in_service_s;
    logic        wd_expire_s;

    rr_pick2 u_pick (
        .pend       (pend_r),
        .last_grant (last_grant_r),
        .valid      (pick_valid_s),
        .grant      (pick_grant_s)
    );

    // Request latches: a kick is taken only while its requester is idle; DONE retires the grant
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_r  <= 2'b00;
            num0_r  <= 32'd0;
            addr0_r <= 32'd0;
            num1_r  <= 32'd0;
            addr1_r <= 32'd0;
        end else begin
            if (req0_kick && !pend_r[0]) begin
                pend_r[0] <= 1'b1;
                num0_r    <= req0_read_num;
                addr0_r   <= req0_read_addr;
            end
            if (req1_kick && !pend_r[1]) begin
                pend_r[1] <= 1'b1;
                num1_r    <= req1_read_num;
                addr1_r   <= req1_read_addr;
            end
            if (state_r == ST_DONE) begin
                pend_r[grant_r] <= 1'b0;
            end
        end
    end

    // Transfer sequencer; dram_kick is raised on the edge that enters ISSUE
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r        <= ST_IDLE;
            grant_r        <= REQ_PIP;
            last_grant_r   <= REQ_BACK;
            dram_kick      <= 1'b0;
            dram_read_num  <= 32'd0;
            dram_read_addr <= 32'd0;
        end else begin
            dram_kick <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s && !dram_busy) begin
                        grant_r        <= pick_grant_s;
                        dram_read_num  <= (pick_grant_s == REQ_BACK) ? num1_r : num0_r;
                        dram_read_addr <= (pick_grant_s == REQ_BACK) ? addr1_r : addr0_r;
                        dram_kick      <= 1'b1;
                        state_r        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (dram_busy) begin
                        state_r <= ST_RUN;
                    end else if (wd_expire_s) begin
                        dram_kick <= 1'b1;
                        state_r   <= ST_ISSUE;
                    end
                end
                ST_RUN: begin
                    if (!dram_busy) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    last_grant_r <= grant_r;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DRAM_ARB_WATCHDOG_EN
    logic [31:0] wd_cnt_r;

    assign wd_expire_s = (state_r == ST_WAIT_BUSY) && !dram_busy && (wd_cnt_r == TIMEOUT - 32'd1);

    // Watchdog: counts from zero on every WAIT_BUSY entry; the error flag holds until reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            wd_cnt_r <= 32'd0;
            arb_err  <= 1'b0;
        end else begin
            if (state_r == ST_WAIT_BUSY) begin
                wd_cnt_r <= wd_cnt_r + 32'd1;
            end else begin
                wd_cnt_r <= 32'd0;
            end
            if (wd_expire_s) begin
                arb_err <= 1'b1;
            end
        end
    end
`else
    assign wd_expire_s = 1'b0;
    assign arb_err     = 1'b0;
`endif

    // Words are only owned by the grant while the DRAM engine may be delivering them
    assign in_service_s  = (state_r == ST_WAIT_BUSY) || (state_r == ST_RUN);
    assign req0_buf_we   = dram_buf_we && in_service_s && (grant_r == REQ_PIP);
    assign req1_buf_we   = dram_buf_we && in_service_s && (grant_r == REQ_BACK);
    assign req0_buf_dout = dram_buf_dout;
    assign req1_buf_dout = dram_buf_dout;
    assign req0_busy     = pend_r[0];
    assign req1_busy     = pend_r[1];

endmodule

// File: tb/tb_dram_read_arbiter.sv
// Self-checking bench for dram_read_arbiter: directed scenarios plus randomized two-requester traffic.
`timescale 1ns/1ps
module tb_dram_read_arbiter;

    logic        CLK;
    logic        RST;
    logic        req0_kick, req1_kick;
    logic [31:0] req0_read_num, req0_read_addr, req1_read_num, req1_read_addr;
    logic        req0_busy, req1_busy, req0_buf_we, req1_buf_we;
    logic [31:0] req0_buf_dout, req1_buf_dout;
    logic        dram_kick;
    logic [31:0] dram_read_num, dram_read_addr;
    logic        dram_busy, dram_buf_we;
    logic [31:0] dram_buf_dout;
    logic        arb_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit [31:0] got0[$], got1[$], exp0[$], exp1[$];
    bit [31:0] kaddr_q[$], knum_q[$];
    int        kcyc_q[$];

    dram_read_arbiter #(.TIMEOUT(16)) dut (
        .CLK(CLK), .RST(RST),
        .req0_kick(req0_kick), .req0_read_num(req0_read_num), .req0_read_addr(req0_read_addr),
        .req0_busy(req0_busy), .req0_buf_dout(req0_buf_dout), .req0_buf_we(req0_buf_we),
        .req1_kick(req1_kick), .req1_read_num(req1_read_num), .req1_read_addr(req1_read_addr),
        .req1_busy(req1_busy), .req1_buf_dout(req1_buf_dout), .req1_buf_we(req1_buf_we),
        .dram_kick(dram_kick), .dram_read_num(dram_read_num), .dram_read_addr(dram_read_addr),
        .dram_busy(dram_busy), .dram_buf_dout(dram_buf_dout), .dram_buf_we(dram_buf_we),
        .arb_err(arb_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Observe delivered words and DRAM kicks away from the active edge
    always @(negedge CLK) begin
        if (req0_buf_we === 1'b1) got0.push_back(req0_buf_dout);
        if (req1_buf_we === 1'b1) got1.push_back(req1_buf_dout);
        if (dram_kick === 1'b1) begin
            kaddr_q.push_back(dram_read_addr);
            knum_q.push_back(dram_read_num);
            kcyc_q.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        req0_kick = 1'b0; req1_kick = 1'b0;
        req0_read_num = 32'd0; req0_read_addr = 32'd0;
        req1_read_num = 32'd0; req1_read_addr = 32'd0;
        dram_busy = 1'b0; dram_buf_we = 1'b0; dram_buf_dout = 32'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
        kaddr_q.delete(); knum_q.delete(); kcyc_q.delete();
    endtask

    task automatic test_reset();
        clear_inputs();
        RST = 1'b1;
        dram_buf_we = 1'b1;
        dram_buf_dout = 32'hDEAD_BEEF;
        tick();
        tick();
        total++; if (req0_busy !== 1'b0) begin bad++; $display("FAIL reset_busy0: got %b want 0", req0_busy); end
        total++; if (req1_busy !== 1'b0) begin bad++; $display("FAIL reset_busy1: got %b want 0", req1_busy); end
        total++; if (dram_kick !== 1'b0) begin bad++; $display("FAIL reset_kick: got %b want 0", dram_kick); end
        total++; if (dram_read_num !== 32'd0) begin bad++; $display("FAIL reset_num: got %0h want 0", dram_read_num); end
        total++; if (dram_read_addr !== 32'd0) begin bad++; $display("FAIL reset_addr: got %0h want 0", dram_read_addr); end
        total++; if (arb_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", arb_err); end
        total++; if ({req1_buf_we, req0_buf_we} !== 2'b00) begin bad++; $display("FAIL reset_we: got %b want 00", {req1_buf_we, req0_buf_we}); end
        dram_buf_we = 1'b0;
        RST = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bit [31:0] w;
        do_reset();
        req0_kick = 1'b1; req0_read_addr = 32'h100; req0_read_num = 32'd640;
        for (int i = 1; i <= 24; i++) begin
            tick();
            req0_kick = 1'b0;
            if (i == 1) begin
                total++; if (req0_busy !== 1'b1) begin bad++; $display("FAIL single_busy_rise: got %b want 1", req0_busy); end
                total++; if (dram_kick !== 1'b0) begin bad++; $display("FAIL single_kick_early: got %b want 0", dram_kick); end
            end
            if (i == 2) begin
                total++; if (dram_kick !== 1'b1) begin bad++; $display("FAIL single_kick: got %b want 1", dram_kick); end
                total++; if (dram_read_addr !== 32'h100) begin bad++; $display("FAIL single_addr: got %0h want 100", dram_read_addr); end
                total++; if (dram_read_num !== 32'd640) begin bad++; $display("FAIL single_num: got %0d want 640", dram_read_num); end
            end
            dram_busy = (i >= 4 && i <= 20);
            w = $urandom();
            dram_buf_dout = w;
            dram_buf_we = (i >= 5 && i <= 12) || i == 2 || i == 22;
            if (i >= 5 && i <= 12) exp0.push_back(w);
            if (i == 21 || i == 22) begin
                total++; if (req0_busy !== 1'b1) begin bad++; $display("FAIL single_busy_hold c%0d: got %b want 1", i, req0_busy); end
            end
            if (i == 23) begin
                total++; if (req0_busy !== 1'b0) begin bad++; $display("FAIL single_busy_fall: got %b want 0", req0_busy); end
            end
        end
        clear_inputs();
        tick();
        total++; if (got0.size() != 8) begin bad++; $display("FAIL single_words0: got %0d want 8", got0.size()); end
        total++; if (got1.size() != 0) begin bad++; $display("FAIL single_words1: got %0d want 0", got1.size()); end
        for (int k = 0; k < exp0.size() && k < got0.size(); k++) begin
            total++; if (got0[k] !== exp0[k]) begin bad++; $display("FAIL single_data[%0d]: got %0h want %0h", k, got0[k], exp0[k]); end
        end
        total++; if (kcyc_q.size() != 1) begin bad++; $display("FAIL single_kicks: got %0d want 1", kcyc_q.size()); end
    endtask

    task automatic test_tie();
        do_reset();
        req0_kick = 1'b1; req0_read_addr = 32'h0;       req0_read_num = 32'd4;
        req1_kick = 1'b1; req1_read_addr = 32'h1000000; req1_read_num = 32'd4;
        for (int i = 1; i <= 22; i++) begin
            tick();
            req0_kick = 1'b0; req1_kick = 1'b0;
            dram_busy = (i >= 4 && i <= 8) || (i >= 14 && i <= 16);
        end
        clear_inputs();
        tick();
        total++; if (kaddr_q.size() != 2) begin bad++; $display("FAIL tie_kicks: got %0d want 2", kaddr_q.size()); end
        total++; if (kaddr_q[0] !== 32'h0) begin bad++; $display("FAIL tie_first: got %0h want 0", kaddr_q[0]); end
        total++; if (kaddr_q[1] !== 32'h1000000) begin bad++; $display("FAIL tie_second: got %0h want 1000000", kaddr_q[1]); end
        total++; if (kcyc_q[1] - kcyc_q[0] != 10) begin bad++; $display("FAIL tie_gap: got %0d want 10", kcyc_q[1] - kcyc_q[0]); end
    endtask

    task automatic test_fairness();
        int n0, n1, rise, fall;
        bit [31:0] a;
        do_reset();
        n0 = 0; n1 = 0; rise = -10; fall = -10;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (dram_kick === 1'b1) begin rise = c + 1; fall = c + 4; end
            dram_busy = (c >= rise && c < fall);
            req0_kick = !req0_busy;
            req0_read_addr = 32'h10 + n0;
            req1_kick = !req1_busy;
            req1_read_addr = 32'h8000_0010 + n1;
            if (req0_kick) n0++;
            if (req1_kick) n1++;
        end
        clear_inputs();
        for (int c = 0; c < 12; c++) tick();
        total++; if (kaddr_q.size() < 4) begin bad++; $display("FAIL fair_kicks: got %0d want >=4", kaddr_q.size()); end
        for (int k = 0; k < 4; k++) begin
            a = kaddr_q[k];
            total++; if (a[31] !== k[0]) begin bad++; $display("FAIL fair_order[%0d]: got %b want %b", k, a[31], k[0]); end
        end
    endtask

    task automatic test_ignored_kick();
        do_reset();
        req0_kick = 1'b1; req0_read_addr = 32'h300; req0_read_num = 32'd5;
        for (int i = 1; i <= 20; i++) begin
            tick();
            req0_kick = (i == 1 || i == 5 || i == 8);
            req0_read_addr = 32'h200;
            req0_read_num = 32'd9;
            dram_busy = (i >= 4 && i <= 6);
        end
        total++; if (req0_busy !== 1'b0) begin bad++; $display("FAIL ign_busy: got %b want 0", req0_busy); end
        clear_inputs();
        tick();
        total++; if (kaddr_q.size() != 1) begin bad++; $display("FAIL ign_kicks: got %0d want 1", kaddr_q.size()); end
        total++; if (kaddr_q[0] !== 32'h300) begin bad++; $display("FAIL ign_addr: got %0h want 300", kaddr_q[0]); end
        total++; if (knum_q[0] !== 32'd5) begin bad++; $display("FAIL ign_num: got %0d want 5", knum_q[0]); end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        req1_kick = 1'b1; req1_read_addr = 32'h8000_4000; req1_read_num = 32'd16;
        for (int i = 1; i <= 14; i++) begin
            tick();
            req1_kick = 1'b0;
            RST = (i == 6);
            dram_busy = (i >= 4 && i <= 11);
            dram_buf_we = (i >= 5 && i <= 10);
            dram_buf_dout = $urandom();
            if (i == 7) begin got0.delete(); got1.delete(); end
            if (i >= 7) begin
                total++; if (dram_kick !== 1'b0) begin bad++; $display("FAIL rst_kick c%0d: got %b want 0", i, dram_kick); end
                total++; if ({req1_busy, req0_busy} !== 2'b00) begin bad++; $display("FAIL rst_busy c%0d: got %b want 00", i, {req1_busy, req0_busy}); end
            end
        end
        clear_inputs();
        tick();
        total++; if (got0.size() + got1.size() != 0) begin bad++; $display("FAIL rst_words: got %0d want 0", got0.size() + got1.size()); end
    endtask

    // Reference: spec timing rules (pend visible the cycle after an accepted kick, decision in an
    // idle cycle, kick the cycle after, busy drops two cycles after DRAM busy is first seen low)
    task automatic test_random_traffic();
        bit [1:0]  mb, acc;
        bit [31:0] ma[2], mn[2];
        bit [31:0] ea, en, w, a;
        bit        last, active, own, in_svc;
        int        kick_at, rise, fall, free_at;
        do_reset();
        mb = 2'b00; last = 1'b1; active = 1'b0; free_at = 0;
        kick_at = -10; rise = -10; fall = -10; own = 1'b0; ea = 32'd0; en = 32'd0;
        for (int c = 0; c < 600; c++) begin
            tick();
            total++; if (dram_kick !== (active && c == kick_at)) begin bad++; $display("FAIL rnd_kick c%0d: got %b want %b", c, dram_kick, active && c == kick_at); end
            if (active && c == kick_at) begin
                total++; if (dram_read_addr !== ea) begin bad++; $display("FAIL rnd_addr c%0d: got %0h want %0h", c, dram_read_addr, ea); end
                total++; if (dram_read_num !== en) begin bad++; $display("FAIL rnd_num c%0d: got %0h want %0h", c, dram_read_num, en); end
            end
            total++; if ({req1_busy, req0_busy} !== mb) begin bad++; $display("FAIL rnd_busy c%0d: got %b want %b", c, {req1_busy, req0_busy}, mb); end
            dram_busy = active && c >= rise && c < fall;
            in_svc = active && c > kick_at && c <= fall;
            w = $urandom();
            dram_buf_dout = w;
            if (in_svc) dram_buf_we = dram_busy && ($urandom_range(0, 1) == 1);
            else        dram_buf_we = ($urandom_range(0, 7) == 0);
            if (in_svc && dram_buf_we) begin
                if (own) exp1.push_back(w); else exp0.push_back(w);
            end
            acc = 2'b00;
            req0_kick = (c < 560) && ($urandom_range(0, 3) == 0);
            a = $urandom(); a[31] = 1'b0;
            req0_read_addr = a; req0_read_num = $urandom();
            if (req0_kick && !mb[0]) begin acc[0] = 1'b1; ma[0] = req0_read_addr; mn[0] = req0_read_num; end
            req1_kick = (c < 560) && ($urandom_range(0, 3) == 0);
            a = $urandom(); a[31] = 1'b1;
            req1_read_addr = a; req1_read_num = $urandom();
            if (req1_kick && !mb[1]) begin acc[1] = 1'b1; ma[1] = req1_read_addr; mn[1] = req1_read_num; end
            if (active && c == fall + 1) begin
                mb[own] = 1'b0; last = own; active = 1'b0; free_at = c + 1;
            end else if (!active && c >= free_at && mb != 2'b00) begin
                own = (mb == 2'b11) ? ~last : mb[1];
                active = 1'b1;
                kick_at = c + 1;
                rise = kick_at + $urandom_range(1, 3);
                fall = rise + $urandom_range(1, 8);
                ea = ma[own]; en = mn[own];
            end
            mb = mb | acc;
        end
        clear_inputs();
        tick();
        total++; if (active || mb != 2'b00) begin bad++; $display("FAIL rnd_drain: active=%b pend=%b want idle", active, mb); end
        total++; if (got0.size() != exp0.size()) begin bad++; $display("FAIL rnd_cnt0: got %0d want %0d", got0.size(), exp0.size()); end
        total++; if (got1.size() != exp1.size()) begin bad++; $display("FAIL rnd_cnt1: got %0d want %0d", got1.size(), exp1.size()); end
        for (int k = 0; k < exp0.size() && k < got0.size(); k++) begin
            total++; if (got0[k] !== exp0[k]) begin bad++; $display("FAIL rnd_data0[%0d]: got %0h want %0h", k, got0[k], exp0[k]); end
        end
        for (int k = 0; k < exp1.size() && k < got1.size(); k++) begin
            total++; if (got1[k] !== exp1[k]) begin bad++; $display("FAIL rnd_data1[%0d]: got %0h want %0h", k, got1[k], exp1[k]); end
        end
    endtask

    task automatic test_watchdog();
        int n;
        do_reset();
        req0_kick = 1'b1; req0_read_addr = 32'h500; req0_read_num = 32'd3;
`ifdef DRAM_ARB_WATCHDOG_EN
        n = 40;
`else
        n = 2000;
`endif
        for (int i = 1; i <= n; i++) begin
            tick();
            req0_kick = 1'b0;
            dram_busy = 1'b0;
            if (i == 10) begin
                total++; if (arb_err !== 1'b0) begin bad++; $display("FAIL wd_err_early: got %b want 0", arb_err); end
            end
        end
`ifdef DRAM_ARB_WATCHDOG_EN
        total++; if (kcyc_q.size() < 2) begin bad++; $display("FAIL wd_rekicks: got %0d want >=2", kcyc_q.size()); end
        total++; if (kcyc_q[1] - kcyc_q[0] != 17) begin bad++; $display("FAIL wd_gap: got %0d want 17", kcyc_q[1] - kcyc_q[0]); end
        total++; if (kaddr_q[1] !== 32'h500) begin bad++; $display("FAIL wd_addr: got %0h want 500", kaddr_q[1]); end
        total++; if (arb_err !== 1'b1) begin bad++; $display("FAIL wd_err: got %b want 1", arb_err); end
`else
        total++; if (kcyc_q.size() != 1) begin bad++; $display("FAIL wd_off_kicks: got %0d want 1", kcyc_q.size()); end
        total++; if (arb_err !== 1'b0) begin bad++; $display("FAIL wd_off_err: got %b want 0", arb_err); end
`endif
    endtask

    initial begin
        RST = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_tie();
        test_fairness();
        test_ignored_kick();
        test_reset_mid_run();
        test_random_traffic();
        test_watchdog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
